reg_file_8: RTL and testbench



---
 rtl/reg_file_8.sv | 64 ++++++
 tb/tb_reg_file_8.sv | 125 ++++++++++++
 2 files changed

// File: rtl/reg_file_8.sv
// reg_file_8: eight-entry register file, one write port, two registered read ports with write-first bypass
//   clk                        rising-edge clock
//   rst_n                      asynchronous active-low reset, clears array and read ports
//   wr_en, wr_addr, wr_data    write request, 3-bit index, data
//   rd_en_a, rd_addr_a         read request and index, port A
//   rd_data_a, rd_valid_a      registered read data and valid, port A
//   rd_en_b, rd_addr_b         read request and index, port B
//   rd_data_b, rd_valid_b      registered read data and valid, port B
module reg_file_8 #(
   parameter int WIDTH    = 16,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en_a,
   input  logic [2:0]       rd_addr_a,
   output logic [WIDTH-1:0] rd_data_a,
   output logic             rd_valid_a,
   input  logic             rd_en_b,
   input  logic [2:0]       rd_addr_b,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_valid_b
);
   logic [7:0]       strobe;
   logic [WIDTH-1:0] regs_q [8];
   logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
   logic             rd_valid_a_q, rd_valid_b_q;
   // a hardwired register 0 never gets a strobe, so it keeps its reset value of 0 and
   // the bypass below (keyed on the strobe) also yields 0 for it
   always_comb
      for (int i = 0; i < 8; i++)
         strobe[i] = wr_en && (wr_addr == 3'(i)) && !(ZERO_REG && i == 0);
   for (genvar g = 0; g < 8; g++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n)
            regs_q[g] <= '0;
         else if (strobe[g])
            regs_q[g] <= wr_data;
   end
   // write-first: a same-cycle write to the read index wins over the array contents
   always_comb begin
      rd_data_a_d = !rd_en_a ? rd_data_a_q : strobe[rd_addr_a] ? wr_data : regs_q[rd_addr_a];
      rd_data_b_d = !rd_en_b ? rd_data_b_q : strobe[rd_addr_b] ? wr_data : regs_q[rd_addr_b];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_data_a_q  <= '0;
         rd_data_b_q  <= '0;
         rd_valid_a_q <= 1'b0;
         rd_valid_b_q <= 1'b0;
      end else begin
         rd_data_a_q  <= rd_data_a_d;
         rd_data_b_q  <= rd_data_b_d;
         rd_valid_a_q <= rd_en_a;
         rd_valid_b_q <= rd_en_b;
      end
   assign rd_data_a  = rd_data_a_q;
   assign rd_data_b  = rd_data_b_q;
   assign rd_valid_a = rd_valid_a_q;
   assign rd_valid_b = rd_valid_b_q;
endmodule

// File: tb/tb_reg_file_8.sv
// tb_reg_file_8: directed and random checks of reg_file_8 in both ZERO_REG builds against a behavioural model
module tb_reg_file_8;
   localparam int W = 16;
   logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0;
   logic [2:0] wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
   logic [W-1:0] wr_data = '0;
   logic [W-1:0] da0, db0, da1, db1;
   logic va0, vb0, va1, vb1;
   int cmp = 0, errs = 0;
   // model state, first index = ZERO_REG setting of the build
   logic [W-1:0] mreg [2][8];
   logic [W-1:0] mda [2], mdb [2];
   logic mva [2], mvb [2];
   always #5 clk = ~clk;
   reg_file_8 #(.WIDTH(W), .ZERO_REG(1'b0)) u_n (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(da0), .rd_valid_a(va0),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(db0), .rd_valid_b(vb0));
   reg_file_8 #(.WIDTH(W), .ZERO_REG(1'b1)) u_z (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(da1), .rd_valid_a(va1),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(db1), .rd_valid_b(vb1));
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int z = 0; z < 2; z++) begin
         for (int i = 0; i < 8; i++) mreg[z][i] = '0;
         mda[z] = '0; mdb[z] = '0; mva[z] = 1'b0; mvb[z] = 1'b0;
      end
   endtask
   // value a read of address a sees this cycle: hardwired zero, else the pending write, else the array
   function automatic logic [W-1:0] mread(input int z, input logic [2:0] a);
      if (z == 1 && a == 3'd0) return '0;
      if (wr_en && wr_addr == a) return wr_data;
      return mreg[z][a];
   endfunction
   task automatic check_all(input string tag);
      chk({tag, ".n.da"}, da0, mda[0]);
      chk({tag, ".n.db"}, db0, mdb[0]);
      chk({tag, ".n.va"}, W'(va0), W'(mva[0]));
      chk({tag, ".n.vb"}, W'(vb0), W'(mvb[0]));
      chk({tag, ".z.da"}, da1, mda[1]);
      chk({tag, ".z.db"}, db1, mdb[1]);
      chk({tag, ".z.va"}, W'(va1), W'(mva[1]));
      chk({tag, ".z.vb"}, W'(vb1), W'(mvb[1]));
   endtask
   task automatic step(input logic we, input logic [2:0] wa, input logic [W-1:0] wd,
                       input logic rea, input logic [2:0] raa, input logic reb, input logic [2:0] rab,
                       input string tag);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en_a = rea; rd_addr_a = raa; rd_en_b = reb; rd_addr_b = rab;
      @(posedge clk);
      if (rst_n)
         for (int z = 0; z < 2; z++) begin
            if (rea) mda[z] = mread(z, raa);
            if (reb) mdb[z] = mread(z, rab);
            mva[z] = rea; mvb[z] = reb;
            if (we && !(z == 1 && wa == 3'd0)) mreg[z][wa] = wd;
         end
      @(negedge clk);
      check_all(tag);
   endtask
   initial begin
      model_reset();
      #1 check_all("reset0");
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1'b1, 3'(i + 1), 16'hDEAD, 1'b1, 3'(i + 1), 1'b1, 3'(i), "in_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 3'(i), 1'b1, 3'(7 - i), "rst_read");
      step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, "rst_idle");
      for (int i = 0; i < 8; i++) step(1'b1, 3'(i), W'(16'h1111 * i), 1'b0, '0, 1'b0, '0, "sweep_wr");
      for (int i = 0; i < 8; i++) begin
         step(1'b0, '0, '0, 1'b1, 3'(i), 1'b1, 3'(7 - i), "sweep_rd");
         chk("sweep.za", da1, W'(16'h1111 * i));
         chk("sweep.zb", db1, W'(16'h1111 * (7 - i)));
      end
      step(1'b1, 3'd5, 16'hBEEF, 1'b1, 3'd5, 1'b1, 3'd4, "bypass");
      chk("bypass.a", da1, 16'hBEEF);
      chk("bypass.b", db1, 16'h4444);
      step(1'b1, 3'd6, 16'h1234, 1'b1, 3'd6, 1'b1, 3'd6, "bypass_both");
      chk("bypass_both", db1, 16'h1234);
      step(1'b1, 3'd0, 16'h9999, 1'b1, 3'd0, 1'b1, 3'd0, "bypass_zero");
      chk("bypass_zero.z", da1, 16'h0000);
      chk("bypass_zero.n", da0, 16'h9999);
      step(1'b0, '0, '0, 1'b1, 3'd3, 1'b0, '0, "hold_rd");
      chk("hold_rd", da1, 16'h3333);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 3'd3, 16'hAAAA, 1'b0, '0, 1'b0, '0, "hold");
         chk("hold.data", da1, 16'h3333);
         chk("hold.valid", W'(va1), '0);
      end
      step(1'b0, '0, '0, 1'b1, 3'd3, 1'b0, '0, "hold_new");
      chk("hold_new", da1, 16'hAAAA);
      step(1'b1, 3'd0, 16'h5A5A, 1'b0, '0, 1'b0, '0, "zr0_wr");
      step(1'b0, '0, '0, 1'b1, 3'd0, 1'b0, '0, "zr0_rd");
      chk("zr0.n", da0, 16'h5A5A);
      chk("zr0.z", da1, 16'h0000);
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 3'($urandom_range(0, 7)), W'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
              1'($urandom), 3'($urandom_range(0, 7)), "rand");
      step(1'b1, 3'd7, 16'h7777, 1'b0, '0, 1'b0, '0, "ar_wr");
      step(1'b0, '0, '0, 1'b1, 3'd7, 1'b1, 3'd7, "ar_rd0");
      step(1'b1, 3'd2, 16'h2222, 1'b1, 3'd7, 1'b1, 3'd7, "ar_rd1");
      chk("ar_rd1", da1, 16'h7777);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      chk("async_rst.a", da1, 16'h0000);
      @(negedge clk);
      step(1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd7, 1'b1, 3'd7, "ar_hold");
      rst_n = 1'b1;
      step(1'b0, '0, '0, 1'b1, 3'd7, 1'b1, 3'd2, "ar_after");
      chk("ar_after", da1, 16'h0000);
      step(1'b1, 3'd4, 16'hC0DE, 1'b0, '0, 1'b0, '0, "first_edge_wr");
      step(1'b0, '0, '0, 1'b1, 3'd4, 1'b0, '0, "first_edge_rd");
      chk("first_edge", da1, 16'hC0DE);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
